// File: rtl/seg7_scan_if.sv
// Load-side handshake and display-side outputs of the 4-digit 7-segment scanner.
interface seg7_scan_if;
    logic        load;
    logic [15:0] valor;
    logic [3:0]  dp_in;
    logic        ready;
    logic [3:0]  dec_in;
    logic [3:0]  dig_en;
    logic        dp;
    logic        frame_tick;

    modport master (
        output load, valor, dp_in,
        input  ready, dec_in, dig_en, dp, frame_tick
    );

    modport slave (
        input  load, valor, dp_in,
        output ready, dec_in, dig_en, dp, frame_tick
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scanner with tear-free double-buffered value load.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl #(
    parameter int unsigned PRESC_DIV = 1000,
    parameter int unsigned GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    seg7_scan_if.slave bus
);

    localparam int unsigned CNT_W = 16;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHOW = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam bit NO_GAP = (GAP_CYC == 0);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(PRESC_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = NO_GAP ? '0 : CNT_W'(GAP_CYC - 1);

    logic [1:0]       state, state_n;
    logic [1:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [15:0]      active, active_n, pend, pend_n;
    logic [3:0]       act_dp, act_dp_n, pend_dp, pend_dp_n;
    logic             pend_vld, pend_vld_n;
    logic             ready_q, ready_n;
    logic [3:0]       dec_q, dec_n;
    logic [3:0]       dig_q, dig_n;
    logic             dp_q, dp_n;
    logic             tick_q, tick_n;
    logic [15:0]      shifted;
    logic             blank;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 2'd0;
            cnt      <= '0;
            active   <= '0;
            act_dp   <= '0;
            pend     <= '0;
            pend_dp  <= '0;
            pend_vld <= 1'b0;
            ready_q  <= 1'b1;
            dec_q    <= '0;
            dig_q    <= 4'b1111;
            dp_q     <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            active   <= active_n;
            act_dp   <= act_dp_n;
            pend     <= pend_n;
            pend_dp  <= pend_dp_n;
            pend_vld <= pend_vld_n;
            ready_q  <= ready_n;
            dec_q    <= dec_n;
            dig_q    <= dig_n;
            dp_q     <= dp_n;
            tick_q   <= tick_n;
        end
    end

    // Next state, handshake and the registered outputs for the upcoming cycle.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt + CNT_W'(1);
        active_n   = active;
        act_dp_n   = act_dp;
        pend_n     = pend;
        pend_dp_n  = pend_dp;
        pend_vld_n = pend_vld;
        ready_n    = ready_q;
        dec_n      = dec_q;
        dig_n      = 4'b1111;
        dp_n       = dp_q;
        tick_n     = 1'b0;
        blank      = 1'b0;
        shifted    = '0;

        case (state)
            IDLE: begin
                state_n = SHOW;
                idx_n   = 2'd0;
                cnt_n   = '0;
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    cnt_n = '0;
                    if (NO_GAP) begin
                        idx_n = idx + 2'd1;
                    end else begin
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = SHOW;
                    idx_n   = idx + 2'd1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = 2'd0;
                cnt_n   = '0;
            end
        endcase

        // tick_q marks the frame-boundary cycle: the only point where active may change.
        if (tick_q) begin
            if (pend_vld) begin
                active_n   = pend;
                act_dp_n   = pend_dp;
                pend_vld_n = 1'b0;
                ready_n    = 1'b1;
            end else if (bus.load && ready_q) begin
                active_n = bus.valor;
                act_dp_n = bus.dp_in;
            end
        end else if (bus.load && ready_q) begin
            pend_n     = bus.valor;
            pend_dp_n  = bus.dp_in;
            pend_vld_n = 1'b1;
            ready_n    = 1'b0;
        end

        shifted = active_n >> {idx_n, 2'b00};
`ifdef SEG7_LZB_EN
        blank = (idx_n != 2'd0) && (shifted == 16'd0);
`else
        blank = 1'b0;
`endif

        case (state_n)
            SHOW: begin
                dec_n = shifted[3:0];
                dp_n  = act_dp_n[idx_n];
                dig_n = blank ? 4'b1111 : ~(4'b0001 << idx_n);
            end
            GAP: begin
                dig_n = 4'b1111;
            end
            default: begin
                dec_n = '0;
                dp_n  = 1'b0;
            end
        endcase

        if (NO_GAP) begin
            tick_n = (state_n == SHOW) && (idx_n == 2'd3) && (cnt_n == SHOW_LAST);
        end else begin
            tick_n = (state_n == GAP) && (idx_n == 2'd3) && (cnt_n == GAP_LAST);
        end
    end

    assign bus.ready      = ready_q;
    assign bus.dec_in     = dec_q;
    assign bus.dig_en     = dig_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: PRESC_DIV=4 with GAP_CYC=1 and GAP_CYC=0 instances.
module tb_seg7_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic rst0_n;
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;
    int   fno    = 0;

    // Reference view of the GAP_CYC=1 instance's buffers.
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_adp, m_pdp;
    logic        m_pv, m_rdy;

    seg7_scan_if ifc ();
    seg7_scan_if ifc0 ();

    seg7_scan_ctrl #(.PRESC_DIV(4), .GAP_CYC(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.slave)
    );

    seg7_scan_ctrl #(.PRESC_DIV(4), .GAP_CYC(0)) dut0 (
        .clk  (clk),
        .rst_n(rst0_n),
        .bus  (ifc0.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One 20-cycle frame starting at digit 0 SHOW cycle 0; optional loads at given cycles.
    task automatic run_frame(input int ld_cyc, input logic [15:0] ld_v, input logic [3:0] ld_d,
                             input int ld2_cyc, input logic [15:0] ld2_v);
        int          d, c;
        logic [3:0]  en, nib;
        logic        pt, tk, lded;
        logic [15:0] lv;
        logic [3:0]  ldp;
        fno++;
        for (int i = 0; i < 20; i++) begin
            d   = i / 5;
            c   = i % 5;
            nib = 4'(m_act >> (d * 4));
            pt  = m_adp[d];
            en  = (c < 4) ? ~(4'b0001 << d) : 4'b1111;
`ifdef SEG7_LZB_EN
            if (d > 0 && (m_act >> (d * 4)) == 16'd0) en = 4'b1111;
`endif
            tk = (i == 19);
            check($sformatf("frame%0d cyc%0d", fno, i),
                  32'({ifc.dig_en, ifc.dec_in, ifc.dp, ifc.frame_tick, ifc.ready}),
                  32'({en, nib, pt, tk, m_rdy}));
            lded = 1'b0;
            lv   = '0;
            ldp  = '0;
            ifc.load = 1'b0;
            if (i == ld_cyc) begin
                ifc.load = 1'b1; ifc.valor = ld_v; ifc.dp_in = ld_d;
                lded = 1'b1; lv = ld_v; ldp = ld_d;
            end
            if (i == ld2_cyc) begin
                ifc.load = 1'b1; ifc.valor = ld2_v; ifc.dp_in = 4'b0000;
                lded = 1'b1; lv = ld2_v; ldp = 4'b0000;
            end
            @(negedge clk);
            if (i == 19) begin
                if (m_pv) begin
                    m_act = m_pend; m_adp = m_pdp; m_pv = 1'b0; m_rdy = 1'b1;
                end else if (lded && m_rdy) begin
                    m_act = lv; m_adp = ldp;
                end
            end else if (lded && m_rdy) begin
                m_pend = lv; m_pdp = ldp; m_pv = 1'b1; m_rdy = 1'b0;
            end
        end
        ifc.load = 1'b0;
    endtask

    initial begin
        int          fr, d;
        logic [15:0] v;
        logic [3:0]  en, nib;
        logic        tk, rdy;

        rst_n = 1'b0; rst0_n = 1'b0;
        ifc.load = 1'b0;  ifc.valor = '0;  ifc.dp_in = '0;
        ifc0.load = 1'b0; ifc0.valor = '0; ifc0.dp_in = '0;
        repeat (2) @(negedge clk);

        check("rst dig_en", 32'(ifc.dig_en), 32'h0000_000F);
        check("rst dec_in", 32'(ifc.dec_in), 32'h0);
        check("rst dp", 32'(ifc.dp), 32'h0);
        check("rst frame_tick", 32'(ifc.frame_tick), 32'h0);
        check("rst ready", 32'(ifc.ready), 32'h1);

        // Release with a load of 1234 on the same edge: pending until the first boundary.
        rst_n = 1'b1;
        ifc.load = 1'b1; ifc.valor = 16'h1234; ifc.dp_in = 4'b0010;
        @(negedge clk);
        ifc.load = 1'b0;
        m_act = '0; m_adp = '0; m_pend = 16'h1234; m_pdp = 4'b0010; m_pv = 1'b1; m_rdy = 1'b0;
        run_frame(-1, '0, '0, -1, '0);

        check("f2 d0 show", 32'({ifc.dig_en, ifc.dec_in}), 32'({4'b1110, 4'h4}));
        // ABCD accepted at cycle 2, 0000 at cycle 7 ignored while ready is low.
        run_frame(2, 16'hABCD, 4'b0101, 7, 16'h0000);

        check("f3 d0 show", 32'({ifc.dig_en, ifc.dec_in, ifc.dp}), 32'({4'b1110, 4'hD, 1'b1}));
        // 0005 in the boundary cycle goes straight to the active register.
        run_frame(19, 16'h0005, 4'b0001, -1, '0);

        check("f4 ready", 32'(ifc.ready), 32'h1);
        run_frame(3, 16'h9876, 4'b0100, -1, '0);

        // Reset during digit 2 SHOW with a load pending.
        check("f5 d0", 32'({ifc.dig_en, ifc.dec_in, ifc.ready}), 32'({4'b1110, 4'h6, 1'b1}));
        repeat (5) @(negedge clk);
        ifc.load = 1'b1; ifc.valor = 16'h1111; ifc.dp_in = 4'b1111;
        @(negedge clk);
        ifc.load = 1'b0;
        check("f5 pending ready", 32'(ifc.ready), 32'h0);
        repeat (5) @(negedge clk);
        check("f5 d2 show", 32'({ifc.dig_en, ifc.dec_in, ifc.dp}), 32'({4'b1011, 4'h8, 1'b1}));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid rst", 32'({ifc.dig_en, ifc.dec_in, ifc.dp, ifc.frame_tick, ifc.ready}),
              32'({4'b1111, 4'h0, 1'b0, 1'b0, 1'b1}));
        rst_n = 1'b1;
        @(negedge clk);
        m_act = '0; m_adp = '0; m_pv = 1'b0; m_rdy = 1'b1;
        run_frame(-1, '0, '0, -1, '0);
        run_frame(-1, '0, '0, -1, '0);

        // GAP_CYC=0 instance: 16-cycle frames, digits back to back.
        rst0_n = 1'b1;
        ifc0.load = 1'b1; ifc0.valor = 16'h4321; ifc0.dp_in = 4'b0000;
        @(negedge clk);
        ifc0.load = 1'b0;
        for (int i = 0; i < 48; i++) begin
            fr  = i / 16;
            d   = (i % 16) / 4;
            v   = (fr == 0) ? 16'h0000 : 16'h4321;
            nib = 4'(v >> (d * 4));
            en  = ~(4'b0001 << d);
`ifdef SEG7_LZB_EN
            if (d > 0 && (v >> (d * 4)) == 16'd0) en = 4'b1111;
`endif
            tk  = ((i % 16) == 15);
            rdy = (fr != 0);
            check($sformatf("nogap cyc%0d", i),
                  32'({ifc0.dig_en, ifc0.dec_in, ifc0.frame_tick, ifc0.ready}),
                  32'({en, nib, tk, rdy}));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
